// File: rtl/pipe_pulse_sequencer_pkg.sv
// rtl/pipe_pulse_sequencer_pkg.sv - shared encodings and state type for the pulse sequencer
package pipe_pulse_pkg;

    // edge_mode field encodings (two bits per channel)
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    // retrig_mode encodings (one bit per channel)
    localparam logic RETRIG_IGNORE  = 1'b0;
    localparam logic RETRIG_RESTART = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        ACTIVE = 2'b10
    } pp_state_t;

    // the shared down-counter must hold either a delay or a length value
    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_pulse_sequencer_if.sv
// rtl/pipe_pulse_sequencer_if.sv - configuration, trigger and pulse signal bundle
interface pipe_pulse_sequencer_if #(
    parameter int CHANNELS = 4,
    parameter int DELAY_W  = 8,
    parameter int LEN_W    = 8
);
    logic [CHANNELS-1:0]         s;
    logic [CHANNELS-1:0]         pipe_in;
    logic [2*CHANNELS-1:0]       edge_mode;
    logic [CHANNELS-1:0]         retrig_mode;
    logic [DELAY_W*CHANNELS-1:0] delay;
    logic [LEN_W*CHANNELS-1:0]   len;
    logic [CHANNELS-1:0]         pulse;
    logic [CHANNELS-1:0]         pipe_out;
    logic [CHANNELS-1:0]         busy;

    modport master (
        output s, pipe_in, edge_mode, retrig_mode, delay, len,
        input  pulse, pipe_out, busy
    );

    modport slave (
        input  s, pipe_in, edge_mode, retrig_mode, delay, len,
        output pulse, pipe_out, busy
    );
endinterface

// File: rtl/pipe_pulse_sequencer_channel.sv
// rtl/pipe_pulse_sequencer_channel.sv - one channel: edge detect, delay/length FSM, registered outputs
module pipe_pulse_channel
    import pipe_pulse_pkg::*;
#(
    parameter int DELAY_W = 8,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s,
    input  logic               pipe_in,
    input  logic [1:0]         edge_mode,
    input  logic               retrig_mode,
    input  logic [DELAY_W-1:0] delay,
    input  logic [LEN_W-1:0]   len,
    output logic               pulse,
    output logic               pipe_out,
    output logic               busy
);
    localparam int CNT_W = max_width(DELAY_W, LEN_W);

    pp_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] len_l, len_l_n;
    logic             pipe_out_n;
    logic             s_prev;
    logic             rise, fall, edge_hit, trig, accept;

    // select the monitored edge; pipe_in is always a trigger source
    always_comb begin
        rise     = s & ~s_prev;
        fall     = ~s & s_prev;
        edge_hit = 1'b0;
        case (edge_mode)
            EDGE_RISE: edge_hit = rise;
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = 1'b0;
        endcase
        trig   = edge_hit | pipe_in;
        accept = trig && (len != '0);
    end

    // next state: a load behaves identically from IDLE, a restart, or a pulse end
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        len_l_n    = len_l;
        pipe_out_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    len_l_n = len;
                    if (delay == '0) begin
                        state_n = ACTIVE;
                        cnt_n   = CNT_W'(len) - CNT_W'(1);
                    end else begin
                        state_n = DELAY;
                        cnt_n   = CNT_W'(delay) - CNT_W'(1);
                    end
                end
            end
            DELAY: begin
                if (accept && (retrig_mode == RETRIG_RESTART)) begin
                    len_l_n = len;
                    if (delay == '0) begin
                        state_n = ACTIVE;
                        cnt_n   = CNT_W'(len) - CNT_W'(1);
                    end else begin
                        state_n = DELAY;
                        cnt_n   = CNT_W'(delay) - CNT_W'(1);
                    end
                end else if (cnt == '0) begin
                    state_n = ACTIVE;
                    cnt_n   = CNT_W'(len_l) - CNT_W'(1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (cnt == '0) begin
                    // completed pulse always reports, even if a new trigger restarts the channel
                    pipe_out_n = 1'b1;
                    state_n    = IDLE;
                end
                if (accept && ((cnt == '0) || (retrig_mode == RETRIG_RESTART))) begin
                    len_l_n = len;
                    if (delay == '0) begin
                        state_n = ACTIVE;
                        cnt_n   = CNT_W'(len) - CNT_W'(1);
                    end else begin
                        state_n = DELAY;
                        cnt_n   = CNT_W'(delay) - CNT_W'(1);
                    end
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            len_l    <= '0;
            s_prev   <= 1'b0;
            pulse    <= 1'b0;
            pipe_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            len_l    <= len_l_n;
            s_prev   <= s;
            pulse    <= (state_n == ACTIVE);
            pipe_out <= pipe_out_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: rtl/pipe_pulse_sequencer.sv
// rtl/pipe_pulse_sequencer.sv - top: CHANNELS independent pulse channels sliced from the bus
module pipe_pulse_sequencer
    import pipe_pulse_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DELAY_W  = 8,
    parameter int LEN_W    = 8
) (
    input logic                    clk,
    input logic                    reset,
    pipe_pulse_sequencer_if.slave  bus
);
    logic [CHANNELS-1:0] pulse_w;
    logic [CHANNELS-1:0] pipe_out_w;
    logic [CHANNELS-1:0] busy_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pipe_pulse_channel #(
            .DELAY_W (DELAY_W),
            .LEN_W   (LEN_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .s           (bus.s[i]),
            .pipe_in     (bus.pipe_in[i]),
            .edge_mode   (bus.edge_mode[2*i +: 2]),
            .retrig_mode (bus.retrig_mode[i]),
            .delay       (bus.delay[DELAY_W*i +: DELAY_W]),
            .len         (bus.len[LEN_W*i +: LEN_W]),
            .pulse       (pulse_w[i]),
            .pipe_out    (pipe_out_w[i]),
            .busy        (busy_w[i])
        );
    end

    assign bus.pulse    = pulse_w;
    assign bus.pipe_out = pipe_out_w;
    assign bus.busy     = busy_w;

endmodule

// File: doc/pipe_pulse_sequencer.md
Name: pipe_pulse_sequencer

Overview:
- Multi-channel, parametrised pulse generator for daisy-chained trigger pipelines.
- Each channel detects a configurable edge on its monitored signal, or accepts a chained trigger on pipe_in.
- After a programmable delay it emits a pulse of programmable length, then issues a one-cycle pipe_out strobe to trigger the next stage.
- Adds retrigger policy and edge selection to the single-width pulse pipe stage.

Parameters:
- CHANNELS, 4: number of independent channels.
- DELAY_W, 8: width of the per-channel delay value.
- LEN_W, 8: width of the per-channel pulse-length value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s  in  CHANNELS  monitored signals, one bit per channel
- pipe_in  in  CHANNELS  chained trigger inputs
- edge_mode  in  2*CHANNELS  per channel: 00 rising, 01 falling, 10 both, 11 edge detect disabled (pipe_in only)
- retrig_mode  in  CHANNELS  per channel: 0 ignore while busy, 1 restart
- delay  in  DELAY_W*CHANNELS  per-channel delay, in cycles
- len  in  LEN_W*CHANNELS  per-channel pulse length, in cycles
- pulse  out  CHANNELS  registered pulse outputs
- pipe_out  out  CHANNELS  registered one-cycle end-of-pulse strobes
- busy  out  CHANNELS  channel in DELAY or ACTIVE

Behaviour:
- Reset: pulse=0, pipe_out=0, busy=0, s_prev=0, all FSMs IDLE, counters 0.
  - Because s_prev resets to 0, s=1 in the first cycle after reset counts as a rising edge.
- Edge detect:
  - s_prev[i] is registered every cycle.
  - rise = s & ~s_prev; fall = ~s & s_prev.
  - trig[i] = (selected edge per edge_mode) | pipe_in[i].
  - A trigger is evaluated combinationally and acted on at the next clock edge (E0).
- Acceptance:
  - A trigger is accepted only when len[i] != 0.
  - len=0 means the trigger is ignored: no pulse, no pipe_out, state unchanged.
  - delay and len are latched at acceptance; later input changes do not affect the pulse in flight.
- FSM per channel: IDLE, DELAY, ACTIVE.
  - IDLE + accepted trigger, delay=0: go to ACTIVE, cnt=len-1, pulse=1 from E0.
  - IDLE + accepted trigger, delay>0: go to DELAY, cnt=delay-1.
  - DELAY: decrement cnt; at cnt=0, go to ACTIVE, cnt=len_l-1, pulse=1.
  - ACTIVE: decrement cnt; at cnt=0, go to IDLE, pulse=0, pipe_out=1 for exactly one cycle.
- Timing:
  - pulse is high during cycles E0+delay+1 .. E0+delay+len.
  - pipe_out is high in cycle E0+delay+len+1.
- Busy-time triggers:
  - retrig_mode=0: triggers while busy are dropped.
  - retrig_mode=1: an accepted trigger reloads as if from IDLE. pulse drops to 0 if delay>0, or stays 1 if delay=0. No pipe_out is emitted for the aborted pulse.
- Simultaneous events:
  - Pulse end and an accepted trigger on the same edge, either mode: the channel restarts, pipe_out=1 is still emitted for the completed pulse, and busy stays 1.
  - Edge and pipe_in in the same cycle count as a single trigger.
- Reset mid-operation aborts immediately to the reset values; no pipe_out is emitted.
- Counters never wrap: the maximum delay and len values are honoured exactly (2^W-1 cycles).
- Channels are fully independent. Cross-channel chaining is external (pipe_out[i] wired to pipe_in[j]).

Decomposition:
- Package pipe_pulse_pkg holds:
  - edge_mode encodings: EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_NONE=2'b11
  - FSM state typedef: IDLE, DELAY, ACTIVE
  - retrig encodings: RETRIG_IGNORE=0, RETRIG_RESTART=1
- Sub-module pipe_pulse_channel contains one channel's edge detect, FSM and counters. The top level generates CHANNELS instances and slices the bus ports.

Test Plan:
- Rising mode, delay=0, len=3; s rises in cycle 5 -> pulse high in cycles 6-8, pipe_out=1 in cycle 9, busy in cycles 6-8.
- Falling mode, delay=4, len=2; s falls in cycle 10 -> pulse high in cycles 15-16, pipe_out in cycle 17; a rising edge in cycle 20 gives no response.
- retrig=0, delay=2, len=5; trigger in cycle 0, second trigger in cycle 4 -> single pulse in cycles 3-7, one pipe_out. Same stimulus with retrig=1 -> pulse in cycles 3-4, drops, pulse again in cycles 7-11, exactly one pipe_out in cycle 12.
- Chain ch0.pipe_out -> ch1.pipe_in, both delay=1, len=2; ch0 trigger at E0=0 -> ch0 pulse in cycles 2-3, pipe_out in 4; ch1 pulse in cycles 6-7, pipe_out in 8.
- len=0 with triggers on pipe_in -> pulse, pipe_out and busy stay 0. Then delay=255, len=255 -> pulse width exactly 255 cycles, starting 256 cycles after E0.
- reset asserted during ACTIVE (pulse=1) -> next cycle: pulse=0, busy=0, no pipe_out. Release reset with s=1 -> rising edge detected and a pulse generated.
